// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared types and constants for the serial program loader.
//               Holds the packet FSM state encoding, the byte-receiver
//               state encoding and the default packet sync marker.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

    // Default packet start marker
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Packet FSM states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_LO   = 3'd2,
        ST_HI   = 3'd3,
        ST_SUM  = 3'd4
    } state_e;

    // UART byte-receiver states
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_if
// Description : Bus bundle between the program loader and its surroundings.
//               rx        - UART line into the loader (idles high)
//               we/waddr/wdata - program-memory write port
//               cpu_hold  - CPU stall request
//               busy/done/error - loader status
//               master : loader side, slave : memory/CPU/bench side.
// Revision    : 1.0 - initial release
// ============================================================================
interface prog_loader_if;
    logic        rx;
    logic        we;
    logic [7:0]  waddr;
    logic [15:0] wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        input  rx,
        output we, waddr, wdata, cpu_hold, busy, done, error
    );

    modport slave (
        output rx,
        input  we, waddr, wdata, cpu_hold, busy, done, error
    );
endinterface
`default_nettype wire

// File: rtl/prog_loader_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART byte receiver with 2-flop input synchronizer,
//               start-bit glitch rejection and stop-bit framing check.
// Ports       : clock      - receiver clock, rising edge
//               nreset     - asynchronous active-low reset
//               rx         - asynchronous serial line, idles high
//               byte_valid - one-cycle pulse with a good byte
//               byte_data  - received byte, valid with byte_valid
//               frame_err  - one-cycle pulse when the stop bit is 0
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  wire logic       clock,
    input  wire logic       nreset,
    input  wire logic       rx,
    output logic            byte_valid,
    output logic [7:0]      byte_data,
    output logic            frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic             meta_q, sync_q, prev_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    // State register; synchronizer resets to the idle line level so that
    // reset release never looks like a falling edge.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            meta_q  <= rx;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                // Mid-start-bit check: line back high means it was a glitch
                if (cnt_q == HALF_CNT) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d   = '0;
                    shift_d = {sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = sync_q;
                    ferr_d  = !sync_q;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        byte_valid = valid_q;
        byte_data  = shift_q;
        frame_err  = ferr_q;
    end

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Serial bootloader. Receives A5/LEN/words/SUM packets over
//               UART, writes each 16-bit word into program memory and holds
//               the CPU stalled until a packet loads successfully.
// Ports       : clock  - 12 MHz clock, rising edge
//               nreset - asynchronous active-low reset
//               bus    - prog_loader_if.master (rx in; we/waddr/wdata,
//                        cpu_hold, busy, done, error out)
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 104,
    parameter int         TIMEOUT_CLKS = 1200000,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  wire logic          clock,
    input  wire logic          nreset,
    prog_loader_if.master      bus
);

    localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ferr;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clock      (clock),
        .nreset     (nreset),
        .rx         (bus.rx),
        .byte_valid (rx_valid),
        .byte_data  (rx_data),
        .frame_err  (rx_ferr)
    );

    state_e          state_q, state_d;
    logic [8:0]      cnt_q, cnt_d;
    logic [8:0]      count_q, count_d;
    logic [7:0]      sum_q, sum_d;
    logic [7:0]      lo_q, lo_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            we_q, we_d;
    logic [7:0]      waddr_q, waddr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic            hold_q, hold_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic [8:0]      cnt_inc;

    assign cnt_inc = cnt_q + 9'd1;

    // State register
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            count_q <= '0;
            sum_q   <= '0;
            lo_q    <= '0;
            to_q    <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            lo_q    <= lo_d;
            to_q    <= to_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        sum_d   = sum_q;
        lo_d    = lo_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        error_d = error_q;

        // Inter-byte idle timer only runs inside a packet
        if (state_q == ST_IDLE || rx_valid) begin
            to_d = '0;
        end else begin
            to_d = to_q + 1'b1;
        end

        if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d = ST_LEN;
                        error_d = 1'b0;
                        hold_d  = 1'b1;
                        cnt_d   = '0;
                        sum_d   = '0;
                    end
                end
                ST_LEN: begin
                    // A length byte of zero encodes a full 256-word load
                    count_d = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                    sum_d   = rx_data;
                    state_d = ST_LO;
                end
                ST_LO: begin
                    lo_d    = rx_data;
                    sum_d   = sum_q + rx_data;
                    state_d = ST_HI;
                end
                ST_HI: begin
                    sum_d   = sum_q + rx_data;
                    we_d    = 1'b1;
                    waddr_d = cnt_q[7:0];
                    wdata_d = {rx_data, lo_q};
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == count_q) ? ST_SUM : ST_LO;
                end
                ST_SUM: begin
                    if (rx_data == sum_q) begin
                        done_d = 1'b1;
                        hold_d = 1'b0;
                    end else begin
                        error_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Framing error or inter-byte timeout aborts a packet in progress;
        // cpu_hold is left asserted so the CPU never runs a partial image.
        if (state_q != ST_IDLE && (rx_ferr || (!rx_valid && to_q == TO_LAST))) begin
            state_d = ST_IDLE;
            error_d = 1'b1;
            we_d    = 1'b0;
            done_d  = 1'b0;
        end

        if (state_q == ST_IDLE && !(rx_valid && rx_data == SYNC_BYTE)) begin
            state_d = ST_IDLE;
        end
    end

    // Outputs
    always_comb begin
        bus.we       = we_q;
        bus.waddr    = waddr_q;
        bus.wdata    = wdata_q;
        bus.cpu_hold = hold_q;
        bus.busy     = (state_q != ST_IDLE);
        bus.done     = done_q;
        bus.error    = error_q;
    end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
# prog_loader

Serial bootloader that writes the program memory the CPU fetches from. It receives an 8N1 UART byte stream on `rx`, checks that each packet is correctly framed and checksummed, and issues one 16-bit write per word into the 256×16 program BRAM. It drives `cpu_hold` to keep the core stalled while a load is in progress. It runs in the 12 MHz CPU clock domain, alongside the fetch side of program memory.

## Interface
- `CLKS_PER_BIT`, 104, clocks per UART bit (12 MHz / 115200).
- `TIMEOUT_CLKS`, 1200000, maximum idle clocks between bytes inside a packet (100 ms).
- `SYNC_BYTE`, 8'hA5, packet start marker.

- `clock`  in  1  12 MHz clock, rising edge.
- `nreset`  in  1  asynchronous, active-low reset.
- `rx`  in  1  UART line, idles high, asynchronous to `clock`.
- `we`  out  1  program-memory write strobe, one cycle per word.
- `waddr`  out  8  word address for the write.
- `wdata`  out  16  word data for the write.
- `cpu_hold`  out  1  stall request to the CPU.
- `busy`  out  1  high while a packet is in progress (state ≠ IDLE).
- `done`  out  1  one-cycle pulse after a packet loads successfully.
- `error`  out  1  sticky failure flag; cleared by the next sync byte.

## Operation
- **Packet format:** `A5`, `LEN`, then LEN words, then `SUM`.
  - Each word is sent low byte then high byte.
  - `LEN` = 0 means 256 words.
  - `SUM` = (LEN + all data bytes) mod 256.
- **Byte receiver:**
  - 2-flop synchronizer on `rx`.
  - A falling edge in idle starts a byte.
  - Resample at `CLKS_PER_BIT/2`. If `rx` is high there, the start was a glitch: return to idle with no error.
  - Take 8 data bits LSB-first at `CLKS_PER_BIT` intervals.
  - The stop bit must be 1. If it is 0, raise a framing error and discard the byte.
  - A good byte produces a one-cycle `byte_valid` with `byte_data`.
- **FSM states:** IDLE, LEN, LO, HI, SUM.
  - IDLE: any byte other than `SYNC_BYTE` is ignored. `SYNC_BYTE` → LEN, with `error`←0, `cpu_hold`←1, word counter←0, checksum←0.
  - LEN: latch the count (0 → 256), seed checksum = LEN, → LO.
  - LO: latch the low byte, add it to the checksum, → HI.
  - HI: add to the checksum. Next cycle drive `we`=1, `waddr`=counter[7:0], `wdata`={hi,lo}, then increment the counter. → SUM if counter+1 = count, else → LO.
  - SUM:
    - Byte equals the checksum: pulse `done`, `cpu_hold`←0, → IDLE.
    - Mismatch: `error`←1, `cpu_hold` stays 1, → IDLE.
- **Mid-packet failures** (framing error or timeout in any state other than IDLE): `error`←1, `cpu_hold` stays 1, → IDLE. No further writes are made.
- Words already written by a failed packet remain in memory. The CPU is only released after a good load.
- `SYNC_BYTE` seen inside a packet is treated as data; it is not a resync.
- **Width rules:**
  - Word counter is 9 bits; `waddr` is its low 8 bits.
  - Checksum is 8 bits and wraps.
  - Timeout counter is sized to `$clog2(TIMEOUT_CLKS+1)`. It resets on every `byte_valid` and counts only while not in IDLE.

## Timing
- **Reset values:** `we`, `waddr`, `wdata`, `cpu_hold`, `busy`, `done`, `error` all 0; FSM in IDLE; receiver idle.
- **Write latency:**
  - `byte_valid` for the HI byte is asserted in the cycle after the stop-bit sample.
  - `we` is asserted the cycle after that.
  - At most one `we` per 2 byte times, so there is no back-pressure.
- `done` is asserted the cycle after `byte_valid` for SUM.
- `cpu_hold` rises the cycle after `byte_valid` for the sync byte.
- **Timing budget:** byte time = 10×`CLKS_PER_BIT` = 1040 clocks. The receiver must tolerate ±2% baud mismatch.
- **Reset mid-packet:** immediate abort with no further writes. `cpu_hold` drops to 0, so the CPU may run partial code; that is the user's responsibility.

## Structure
- Package `prog_loader_pkg` holds:
  - FSM state enum;
  - `SYNC_BYTE` default;
  - byte-receiver state enum (IDLE, START, DATA, STOP).
- Sub-module `uart_rx` handles `clock`, `nreset`, `rx` and outputs `byte_valid`, `byte_data[7:0]`, `frame_err`. It is reusable by later debug-console blocks.
- The top level `prog_loader` contains the packet FSM, checksum, word counter and timeout.

## Test plan
1. **Good two-word packet:** send `A5 02 34 12 CD AB C0` → `we` at `waddr`=0 with `wdata`=16'h1234, then `waddr`=1 with `wdata`=16'hABCD. Then `done` pulses, `error`=0, `cpu_hold` 1→0.
2. **Bad checksum:** send `A5 02 34 12 CD AB C1` → both writes occur, no `done`, `error`=1, `cpu_hold` stays 1. A following good packet clears `error`.
3. **Leading garbage:** send `00 FF 5A` then the packet from test 1 → the garbage bytes cause no writes and no error; the result is identical to test 1.
4. **Full-length packet:** `LEN`=00 with 256 words, word i = i×257 → 256 writes with `waddr` 0..255, then `done`. The checksum wraps correctly.
5. **Framing and glitch:**
   - Second data byte sent with stop bit = 0 → `error`=1, back in IDLE, only the first byte latched, no `we`.
   - A 30-clock low glitch on `rx` → no byte, no error.
6. **Timeout and reset:**
   - Stop after `A5 02 34` → `error`=1 at `TIMEOUT_CLKS` after the last byte.
   - Assert `nreset` mid-packet → all outputs 0 immediately. The next full packet loads normally.
